mod_updown_counter: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 38 +++
 rtl/mod_updown_counter.sv | 134 +++++++++++++
 tb/tb_mod_updown_counter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants, operation decode and parameter checks for stopwatch digit stages.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W              = 4;
  localparam int unsigned MOD_DECIMAL          = 10;
  localparam int unsigned MOD_SEXAGESIMAL_TENS = 6;
  localparam int unsigned MOD_HOURS            = 24;

  // Operation applied to a digit on one clock edge, after priority resolution.
  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_UP   = 3'd3,
    OP_DOWN = 3'd4
  } digit_op_e;

  // Priority: clear beats load beats count beats hold.
  function automatic digit_op_e decode_op(input logic clr, input logic load,
                                          input logic count, input logic up_dn);
    digit_op_e op;
    op = OP_HOLD;
    if (clr) begin
      op = OP_CLR;
    end else if (load) begin
      op = OP_LOAD;
    end else if (count) begin
      op = up_dn ? OP_UP : OP_DOWN;
    end
    return op;
  endfunction

  // A modulus must give at least two states and fit in the digit width.
  function automatic bit modulus_legal(input int unsigned width, input int unsigned modulus);
    return (modulus >= 2) && (64'(modulus) <= (64'(1) << width));
  endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down digit counter with clear, range-checked load and
// combinational carry/borrow for same-cycle cascading.
// Optional sticky wrap flag output ovf when MOD_COUNTER_OVF_EN is defined.
module mod_updown_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned WIDTH   = DIGIT_W,
  parameter int unsigned MODULUS = MOD_DECIMAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             count,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             load_err
`ifdef MOD_COUNTER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned      CMP_W   = WIDTH + 1;
  localparam logic [WIDTH-1:0] TERM    = WIDTH'(MODULUS - 1);
  localparam logic [CMP_W-1:0] MOD_EXT = CMP_W'(MODULUS);

  // Reject moduli that cannot be represented or give fewer than two states.
  if (!modulus_legal(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
  end

  digit_op_e        op;
  logic             at_top;
  logic             at_zero;
  logic             q_illegal;
  logic             load_ok;
  logic [WIDTH-1:0] q_nxt;
  logic             err_nxt;

  // Resolve the per-edge operation and the terminal-count / range compares.
  always_comb begin
    op        = decode_op(clr, load, count, up_dn);
    at_top    = (q == TERM);
    at_zero   = (q == '0);
    q_illegal = (CMP_W'(q) >= MOD_EXT);
    load_ok   = (CMP_W'(d) < MOD_EXT);
  end

  // Carry on up-count at terminal value, borrow on down-count at zero.
  always_comb begin
    co = 1'b0;
    if (op == OP_UP) begin
      co = at_top;
    end else if (op == OP_DOWN) begin
      co = at_zero;
    end
  end

  // Next count and load error flag; an illegal count value recovers to zero.
  always_comb begin
    q_nxt   = q;
    err_nxt = 1'b0;
    case (op)
      OP_CLR: begin
        q_nxt = '0;
      end
      OP_LOAD: begin
        if (load_ok) begin
          q_nxt = d;
        end else begin
          q_nxt   = TERM;
          err_nxt = 1'b1;
        end
      end
      OP_UP: begin
        if (at_top || q_illegal) begin
          q_nxt = '0;
        end else begin
          q_nxt = q + WIDTH'(1);
        end
      end
      OP_DOWN: begin
        if (q_illegal) begin
          q_nxt = '0;
        end else if (at_zero) begin
          q_nxt = TERM;
        end else begin
          q_nxt = q - WIDTH'(1);
        end
      end
      default: begin
        q_nxt = q;
      end
    endcase
  end

  // Count and load error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q        <= '0;
      load_err <= 1'b0;
    end else begin
      q        <= q_nxt;
      load_err <= err_nxt;
    end
  end

`ifdef MOD_COUNTER_OVF_EN
  logic ovf_nxt;

  // Sticky wrap flag: clear and load win, otherwise any carry/borrow sets it.
  always_comb begin
    ovf_nxt = ovf;
    if ((op == OP_CLR) || (op == OP_LOAD)) begin
      ovf_nxt = 1'b0;
    end else if (co) begin
      ovf_nxt = 1'b1;
    end
  end

  // Wrap flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three standalone digits (mod 10, 6, 16) sharing
// controls, plus a mod-10 / mod-6 cascade, against an arithmetic reference model.
module tb_mod_updown_counter;

  logic       clk;
  logic       reset;
  logic       clr, load, count, up_dn;
  logic [3:0] d;
  logic [3:0] q   [3];
  logic       co  [3];
  logic       err [3];
  logic       ovf [3];

  logic       cclr, cload, ccount, cup;
  logic [3:0] du, dt;
  logic [3:0] uq, tq;
  logic       uco, tco, ue, te, uovf, tovf;

  int mods [3] = '{10, 6, 16};
  int mq [3];
  int me [3];
  int mo [3];
  int cu, ct, cue, cte, cuo, cto;

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int unsigned M = (i == 0) ? stopwatch_pkg::MOD_DECIMAL :
                                (i == 1) ? stopwatch_pkg::MOD_SEXAGESIMAL_TENS : 16;
    mod_updown_counter #(.WIDTH(stopwatch_pkg::DIGIT_W), .MODULUS(M)) u_dut (
      .clk(clk), .reset(reset), .clr(clr), .load(load), .count(count),
      .up_dn(up_dn), .d(d), .q(q[i]), .co(co[i]), .load_err(err[i])
`ifdef MOD_COUNTER_OVF_EN
      , .ovf(ovf[i])
`endif
    );
`ifndef MOD_COUNTER_OVF_EN
    assign ovf[i] = 1'b0;
`endif
  end

  mod_updown_counter #(.WIDTH(4), .MODULUS(stopwatch_pkg::MOD_DECIMAL)) u_units (
    .clk(clk), .reset(reset), .clr(cclr), .load(cload), .count(ccount),
    .up_dn(cup), .d(du), .q(uq), .co(uco), .load_err(ue)
`ifdef MOD_COUNTER_OVF_EN
    , .ovf(uovf)
`endif
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(stopwatch_pkg::MOD_SEXAGESIMAL_TENS)) u_tens (
    .clk(clk), .reset(reset), .clr(cclr), .load(cload), .count(uco),
    .up_dn(cup), .d(dt), .q(tq), .co(tco), .load_err(te)
`ifdef MOD_COUNTER_OVF_EN
    , .ovf(tovf)
`endif
  );

`ifndef MOD_COUNTER_OVF_EN
  assign uovf = 1'b0;
  assign tovf = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference digit: modular arithmetic on an integer value.
  task automatic upd(input int m, inout int vq, inout int ve, inout int vo,
                     input logic c_clr, input logic c_load, input logic c_cnt,
                     input logic c_up, input int dv);
    if (c_clr) begin
      vq = 0; ve = 0; vo = 0;
    end else if (c_load) begin
      if (dv < m) begin vq = dv; ve = 0; end
      else begin vq = m - 1; ve = 1; end
      vo = 0;
    end else begin
      ve = 0;
      if (c_cnt) begin
        if (c_up ? ((vq + 1) % m == 0) : (vq == 0)) vo = 1;
        vq = c_up ? (vq + 1) % m : (vq + m - 1) % m;
      end
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("q[%0d]", i), 32'(q[i]), mq[i]);
      chk($sformatf("load_err[%0d]", i), 32'(err[i]), me[i]);
`ifdef MOD_COUNTER_OVF_EN
      chk($sformatf("ovf[%0d]", i), 32'(ovf[i]), mo[i]);
`endif
    end
    chk("casc_units_q", 32'(uq), cu);
    chk("casc_tens_q", 32'(tq), ct);
    chk("casc_units_err", 32'(ue), cue);
    chk("casc_tens_err", 32'(te), cte);
`ifdef MOD_COUNTER_OVF_EN
    chk("casc_units_ovf", 32'(uovf), cuo);
    chk("casc_tens_ovf", 32'(tovf), cto);
`endif
  endtask

  // Called at a falling edge with inputs already set: check carries, advance model, check registers.
  task automatic step();
    logic ucarry;
    int   v;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("co[%0d]", i), 32'(co[i]),
          32'(count && !clr && !load && (up_dn ? (mq[i] + 1 == mods[i]) : (mq[i] == 0))));
    end
    v      = 10 * ct + cu;
    ucarry = ccount && !cclr && !cload && (cup ? (cu == 9) : (cu == 0));
    chk("casc_units_co", 32'(uco), 32'(ucarry));
    chk("casc_tens_co", 32'(tco),
        32'(ccount && !cclr && !cload && (cup ? (v == 59) : (v == 0))));
    for (int i = 0; i < 3; i++) upd(mods[i], mq[i], me[i], mo[i], clr, load, count, up_dn, int'(d));
    upd(10, cu, cue, cuo, cclr, cload, ccount, cup, int'(du));
    upd(6, ct, cte, cto, cclr, cload, ucarry, cup, int'(dt));
    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin mq[i] = 0; me[i] = 0; mo[i] = 0; end
    cu = 0; ct = 0; cue = 0; cte = 0; cuo = 0; cto = 0;
  endtask

  task automatic idle();
    clr = 0; load = 0; count = 0; up_dn = 1; d = '0;
    cclr = 0; cload = 0; ccount = 0; cup = 1; du = '0; dt = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_q0", 32'(q[0]), 0);
    chk("reset_err0", 32'(err[0]), 0);
    chk("reset_co0", 32'(co[0]), 0);
    reset = 1'b0;

    // Reset mid-count: load 7, then assert reset between edges.
    load = 1; d = 4'd7; step();
    chk("pre_reset_q", 32'(q[0]), 7);
    idle(); count = 1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_reset_q0", 32'(q[0]), 0);
    chk("async_reset_err1", 32'(err[1]), 0);
    check_regs();
    @(posedge clk);
    @(negedge clk);
    chk("reset_held_q0", 32'(q[0]), 0);
    check_regs();
    reset = 1'b0;

    // Up wrap on mod 10.
    idle(); load = 1; d = 4'd8; step();
    idle(); count = 1; up_dn = 1;
    step(); chk("up_wrap_9", 32'(q[0]), 9);
    step(); chk("up_wrap_0", 32'(q[0]), 0);
    step(); chk("up_wrap_1", 32'(q[0]), 1);

    // Down wrap on mod 6.
    idle(); load = 1; d = 4'd1; step();
    idle(); count = 1; up_dn = 0;
    step(); chk("down_wrap_0", 32'(q[1]), 0);
    #1 chk("down_borrow", 32'(co[1]), 1);
    step(); chk("down_wrap_5", 32'(q[1]), 5);
    step(); chk("down_wrap_4", 32'(q[1]), 4);

    // Out-of-range load then legal load.
    idle(); load = 1; d = 4'd13; step();
    chk("oor_q", 32'(q[0]), 9);
    chk("oor_err", 32'(err[0]), 1);
    d = 4'd3; step();
    chk("reload_q", 32'(q[0]), 3);
    chk("reload_err", 32'(err[0]), 0);

    // Priority: clear beats load beats count.
    idle(); load = 1; d = 4'd9; step();
    clr = 1; load = 1; count = 1; up_dn = 1; d = 4'd5;
    #1 chk("prio_co", 32'(co[0]), 0);
    step(); chk("prio_clr_q", 32'(q[0]), 0);
    clr = 0; step(); chk("prio_load_q", 32'(q[0]), 5);

    // Cascade 59 -> 00.
    idle(); cload = 1; du = 4'd9; dt = 4'd5; step();
    idle(); ccount = 1; cup = 1;
    #1 chk("casc_tens_co_59", 32'(tco), 1);
    step();
    chk("casc_units_00", 32'(uq), 0);
    chk("casc_tens_00", 32'(tq), 0);
`ifdef MOD_COUNTER_OVF_EN
    chk("casc_ovf_set", 32'(tovf), 1);
`endif
    idle(); cclr = 1; step();
`ifdef MOD_COUNTER_OVF_EN
    chk("casc_ovf_clr", 32'(tovf), 0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      clr    = ($urandom_range(0, 99) < 5);
      load   = ($urandom_range(0, 99) < 15);
      count  = ($urandom_range(0, 99) < 75);
      up_dn  = 1'($urandom_range(0, 1));
      d      = 4'($urandom_range(0, 15));
      cclr   = ($urandom_range(0, 99) < 4);
      cload  = ($urandom_range(0, 99) < 10);
      ccount = ($urandom_range(0, 99) < 80);
      cup    = 1'($urandom_range(0, 1));
      du     = 4'($urandom_range(0, 15));
      dt     = 4'($urandom_range(0, 15));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
